// File: rtl/bus_ctrl_pkg.sv
// Shared encodings for the register-bus transfer controller.
// Holds the instruction opcodes and the sequencer step states.
package bus_ctrl_pkg;

  localparam logic [1:0] OP_MV  = 2'd0;
  localparam logic [1:0] OP_MVI = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_SUB = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

endpackage

// File: rtl/reg_sel_dec.sv
// One-hot register select decoder.
// Produces all zeros when disabled or when the index names no real register.
module reg_sel_dec #(
  parameter int NREG  = 8,
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  onehot
);

  // An index at or beyond NREG never matches any bit, so it decodes to zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      if (en && (idx == REG_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Multi-cycle sequencer for the shared register bus: MV, MVI, ADD and SUB.
// Only one bus driver is ever enabled in a given cycle.
module bus_xfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       op,
  input  logic [REG_W-1:0] rx,
  input  logic [REG_W-1:0] ry,
  output logic [NREG-1:0]  R_in,
  output logic [NREG-1:0]  R_out,
  output logic             A_in,
  output logic             G_in,
  output logic             G_out,
  output logic             ext_out,
  output logic             alu_sub,
  output logic             done
);

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [REG_W-1:0] rx_q, ry_q;
  logic             in_en, out_en;
  logic [REG_W-1:0] in_idx, out_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fields are captured once at acceptance; outputs never look at the live inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0;
      rx_q <= '0;
      ry_q <= '0;
    end else if (state == S_IDLE && instr_valid) begin
      op_q <= op;
      rx_q <= rx;
      ry_q <= ry;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (instr_valid) state_nxt = S_T1;
      S_T1:   state_nxt = (op_q == OP_ADD || op_q == OP_SUB) ? S_T2 : S_IDLE;
      S_T2:   state_nxt = S_T3;
      S_T3:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == S_IDLE);
    in_en       = 1'b0;
    in_idx      = rx_q;
    out_en      = 1'b0;
    out_idx     = ry_q;
    A_in        = 1'b0;
    G_in        = 1'b0;
    G_out       = 1'b0;
    ext_out     = 1'b0;
    alu_sub     = 1'b0;
    done        = 1'b0;
    case (state)
      S_T1: begin
        case (op_q)
          OP_MV: begin
            out_en = 1'b1;
            in_en  = 1'b1;
            done   = 1'b1;
          end
          OP_MVI: begin
            ext_out = 1'b1;
            in_en   = 1'b1;
            done    = 1'b1;
          end
          default: begin
            out_en  = 1'b1;
            out_idx = rx_q;
            A_in    = 1'b1;
          end
        endcase
      end
      S_T2: begin
        out_en  = 1'b1;
        G_in    = 1'b1;
        alu_sub = (op_q == OP_SUB);
      end
      S_T3: begin
        G_out = 1'b1;
        in_en = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  reg_sel_dec #(.NREG(NREG), .REG_W(REG_W)) u_in_dec (
    .idx    (in_idx),
    .en     (in_en),
    .onehot (R_in)
  );

  reg_sel_dec #(.NREG(NREG), .REG_W(REG_W)) u_out_dec (
    .idx    (out_idx),
    .en     (out_en),
    .onehot (R_out)
  );

endmodule
